cart_map_arbiter: RTL and testbench

- Parametrised N-channel cartridge-mapper arbiter at SNES top level; routes one mapper's CPU data, IRQ, ROM and BSRAM bus to the shared cartridge memories.
- Supersedes fixed one-hot case selection with a registered selection, a drain/guard switchover sequence, one-hot error detection and a per-channel turbo-permit mask.
- Channel 0 is the default mapper (DSP/LoROM/HiROM); channels 1..N-1 are coprocessor mappers.

---
 rtl/cart_map_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_cart_map_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cart_map_arbiter.sv
// N-channel cartridge-mapper arbiter: routes the bus of the selected mapper channel to the
// shared cartridge memories, with a drain/guard switchover. Optional stats: CART_MAP_STATS_EN.
module cart_map_arbiter #(
    parameter int              NUM_CH        = 5,
    parameter int              ROM_AW        = 24,
    parameter int              BSRAM_AW      = 20,
    parameter int              GUARD_CYCLES  = 4,
    parameter int              DRAIN_TIMEOUT = 64,
    parameter logic [NUM_CH-1:0] TURBO_MASK  = 5'b10101
) (
    input  logic                       mclk,
    input  logic                       rst,
    input  logic [NUM_CH-2:0]          map_active,
    input  logic [NUM_CH*8-1:0]        ch_do,
    input  logic [NUM_CH-1:0]          ch_irq_n,
    input  logic [NUM_CH*ROM_AW-1:0]   ch_rom_addr,
    input  logic [NUM_CH-1:0]          ch_rom_ce_n,
    input  logic [NUM_CH-1:0]          ch_rom_oe_n,
    input  logic [NUM_CH-1:0]          ch_rom_word,
    input  logic [NUM_CH*BSRAM_AW-1:0] ch_bsram_addr,
    input  logic [NUM_CH*8-1:0]        ch_bsram_d,
    input  logic [NUM_CH-1:0]          ch_bsram_ce_n,
    input  logic [NUM_CH-1:0]          ch_bsram_oe_n,
    input  logic [NUM_CH-1:0]          ch_bsram_we_n,
    output logic [7:0]                 di,
    output logic                       irq_n,
    output logic [ROM_AW-1:0]          rom_addr,
    output logic                       rom_ce_n,
    output logic                       rom_oe_n,
    output logic                       rom_word,
    output logic [BSRAM_AW-1:0]        bsram_addr,
    output logic [7:0]                 bsram_d,
    output logic                       bsram_ce_n,
    output logic                       bsram_oe_n,
    output logic                       bsram_we_n,
    output logic [2:0]                 sel_idx,
    output logic                       switching,
    output logic                       onehot_err,
    output logic                       turbo_allow
`ifdef CART_MAP_STATS_EN
    ,
    output logic [15:0]                switch_count,
    output logic                       drain_timeout_seen
`endif
);

    localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [2:0]    target_q, target_d;
    logic [2:0]    sel_q, sel_d;
    logic          onehot_err_q, onehot_err_d;

    logic [2:0]    req;
    logic [3:0]    hot_cnt;
    logic          multi_hot;
    logic [SW-1:0] sel_ix;
    logic          released;
    logic          drain_limit;
    logic          guard_last;

    // Per-channel views of the packed input buses
    logic [7:0]          do_a      [NUM_CH];
    logic [ROM_AW-1:0]   rom_addr_a[NUM_CH];
    logic [BSRAM_AW-1:0] bs_addr_a [NUM_CH];
    logic [7:0]          bs_d_a    [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
        assign do_a[gi]       = ch_do[gi*8 +: 8];
        assign rom_addr_a[gi] = ch_rom_addr[gi*ROM_AW +: ROM_AW];
        assign bs_addr_a[gi]  = ch_bsram_addr[gi*BSRAM_AW +: BSRAM_AW];
        assign bs_d_a[gi]     = ch_bsram_d[gi*8 +: 8];
    end

    // Anything other than exactly one hot bit falls back to the default channel
    always_comb begin
        req     = 3'd0;
        hot_cnt = 4'd0;
        for (int k = 1; k < NUM_CH; k++) begin
            if (map_active[k-1]) begin
                hot_cnt = hot_cnt + 4'd1;
                req     = 3'(k);
            end
        end
        if (hot_cnt != 4'd1) begin
            req = 3'd0;
        end
        multi_hot = (hot_cnt > 4'd1);
    end

    assign sel_ix      = sel_q[SW-1:0];
    assign released    = ch_rom_ce_n[sel_ix] & ch_bsram_ce_n[sel_ix];
    assign drain_limit = (dcnt_q == DW'(DRAIN_TIMEOUT - 1));
    assign guard_last  = (gcnt_q == GW'(GUARD_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        dcnt_d       = dcnt_q;
        gcnt_d       = gcnt_q;
        target_d     = target_q;
        sel_d        = sel_q;
        onehot_err_d = onehot_err_q | multi_hot;
        case (state_q)
            S_RUN: begin
                if (req != sel_q) begin
                    state_d = S_DRAIN;
                    dcnt_d  = '0;
                end
            end
            S_DRAIN: begin
                // Target is sampled only here, so request churn during DRAIN is harmless
                if (released || drain_limit) begin
                    state_d  = S_GUARD;
                    gcnt_d   = '0;
                    target_d = req;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            S_GUARD: begin
                if (guard_last) begin
                    state_d = S_RUN;
                    sel_d   = target_q;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_GUARD;
                gcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q      <= S_GUARD;
            dcnt_q       <= '0;
            gcnt_q       <= '0;
            target_q     <= 3'd0;
            sel_q        <= 3'd0;
            onehot_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dcnt_q       <= dcnt_d;
            gcnt_q       <= gcnt_d;
            target_q     <= target_d;
            sel_q        <= sel_d;
            onehot_err_q <= onehot_err_d;
        end
    end

    // Zero-latency pass-through outside GUARD; bus parked while switching over
    always_comb begin
        di         = 8'hFF;
        irq_n      = 1'b1;
        rom_addr   = '0;
        rom_ce_n   = 1'b1;
        rom_oe_n   = 1'b1;
        rom_word   = 1'b0;
        bsram_addr = '0;
        bsram_d    = 8'h00;
        bsram_ce_n = 1'b1;
        bsram_oe_n = 1'b1;
        bsram_we_n = 1'b1;
        if (state_q != S_GUARD) begin
            di         = do_a[sel_ix];
            irq_n      = ch_irq_n[sel_ix];
            rom_addr   = rom_addr_a[sel_ix];
            rom_ce_n   = ch_rom_ce_n[sel_ix];
            rom_oe_n   = ch_rom_oe_n[sel_ix];
            rom_word   = ch_rom_word[sel_ix];
            bsram_addr = bs_addr_a[sel_ix];
            bsram_d    = bs_d_a[sel_ix];
            bsram_ce_n = ch_bsram_ce_n[sel_ix];
            bsram_oe_n = ch_bsram_oe_n[sel_ix];
            bsram_we_n = ch_bsram_we_n[sel_ix];
        end
    end

    assign sel_idx     = sel_q;
    assign switching   = (state_q != S_RUN);
    assign onehot_err  = onehot_err_q;
    assign turbo_allow = (state_q == S_RUN) & TURBO_MASK[sel_ix];

`ifdef CART_MAP_STATS_EN
    logic [15:0] switch_count_q;
    logic        drain_timeout_seen_q;

    always_ff @(posedge mclk) begin
        if (rst) begin
            switch_count_q       <= 16'd0;
            drain_timeout_seen_q <= 1'b0;
        end else begin
            if (state_q == S_GUARD && guard_last && switch_count_q != 16'hFFFF) begin
                switch_count_q <= switch_count_q + 16'd1;
            end
            if (state_q == S_DRAIN && drain_limit && !released) begin
                drain_timeout_seen_q <= 1'b1;
            end
        end
    end

    assign switch_count       = switch_count_q;
    assign drain_timeout_seen = drain_timeout_seen_q;
`endif

endmodule

// File: tb/tb_cart_map_arbiter.sv
// Directed bench for cart_map_arbiter: reset, pass-through, switchover timing, drain timeout,
// one-hot error, in-drain toggling and reset during GUARD.
module tb_cart_map_arbiter;
    localparam int NUM_CH   = 5;
    localparam int ROM_AW   = 24;
    localparam int BSRAM_AW = 20;

    logic                       mclk = 1'b0;
    logic                       rst;
    logic [NUM_CH-2:0]          map_active;
    logic [NUM_CH*8-1:0]        ch_do;
    logic [NUM_CH-1:0]          ch_irq_n;
    logic [NUM_CH*ROM_AW-1:0]   ch_rom_addr;
    logic [NUM_CH-1:0]          ch_rom_ce_n, ch_rom_oe_n, ch_rom_word;
    logic [NUM_CH*BSRAM_AW-1:0] ch_bsram_addr;
    logic [NUM_CH*8-1:0]        ch_bsram_d;
    logic [NUM_CH-1:0]          ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n;
    logic [7:0]                 di;
    logic                       irq_n;
    logic [ROM_AW-1:0]          rom_addr;
    logic                       rom_ce_n, rom_oe_n, rom_word;
    logic [BSRAM_AW-1:0]        bsram_addr;
    logic [7:0]                 bsram_d;
    logic                       bsram_ce_n, bsram_oe_n, bsram_we_n;
    logic [2:0]                 sel_idx;
    logic                       switching, onehot_err, turbo_allow;
`ifdef CART_MAP_STATS_EN
    logic [15:0]                switch_count;
    logic                       drain_timeout_seen;
    logic [15:0]                sc_before;
`endif

    int checks   = 0;
    int failures = 0;

    cart_map_arbiter dut (
        .mclk(mclk), .rst(rst), .map_active(map_active),
        .ch_do(ch_do), .ch_irq_n(ch_irq_n), .ch_rom_addr(ch_rom_addr),
        .ch_rom_ce_n(ch_rom_ce_n), .ch_rom_oe_n(ch_rom_oe_n), .ch_rom_word(ch_rom_word),
        .ch_bsram_addr(ch_bsram_addr), .ch_bsram_d(ch_bsram_d),
        .ch_bsram_ce_n(ch_bsram_ce_n), .ch_bsram_oe_n(ch_bsram_oe_n), .ch_bsram_we_n(ch_bsram_we_n),
        .di(di), .irq_n(irq_n), .rom_addr(rom_addr), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n),
        .rom_word(rom_word), .bsram_addr(bsram_addr), .bsram_d(bsram_d),
        .bsram_ce_n(bsram_ce_n), .bsram_oe_n(bsram_oe_n), .bsram_we_n(bsram_we_n),
        .sel_idx(sel_idx), .switching(switching), .onehot_err(onehot_err), .turbo_allow(turbo_allow)
`ifdef CART_MAP_STATS_EN
        , .switch_count(switch_count), .drain_timeout_seen(drain_timeout_seen)
`endif
    );

    always #5 mclk = ~mclk;

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst        = 1'b1;
        map_active = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_do[k*8 +: 8]                    = 8'hA0 + 8'(k);
            ch_rom_addr[k*ROM_AW +: ROM_AW]    = 24'h100000 * 24'(k) + 24'h000ABC;
            ch_bsram_addr[k*BSRAM_AW +: BSRAM_AW] = 20'h01000 * 20'(k) + 20'h00005;
            ch_bsram_d[k*8 +: 8]               = 8'h50 + 8'(k);
        end
        ch_rom_addr[0 +: ROM_AW] = 24'h123456;
        ch_irq_n      = 5'b01111;
        ch_rom_ce_n   = '1;
        ch_rom_oe_n   = '0;
        ch_rom_word   = '1;
        ch_bsram_ce_n = '1;
        ch_bsram_oe_n = '0;
        ch_bsram_we_n = '1;

        // Reset state: parked bus
        tick(); tick();
        check("rst_switching", 32'(switching), 32'd1);
        check("rst_sel", 32'(sel_idx), 32'd0);
        check("rst_turbo", 32'(turbo_allow), 32'd0);
        check("rst_di", 32'(di), 32'hFF);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_rom_ce_n", 32'(rom_ce_n), 32'd1);
        check("rst_onehot_err", 32'(onehot_err), 32'd0);
        rst = 1'b0;

        // Four GUARD cycles after reset release, then RUN on channel 0
        for (int i = 1; i < 4; i++) begin
            tick();
            check("boot_guard_switching", 32'(switching), 32'd1);
        end
        tick();
        check("boot_run_switching", 32'(switching), 32'd0);
        check("boot_sel", 32'(sel_idx), 32'd0);
        check("boot_turbo", 32'(turbo_allow), 32'd1);
        check("ch0_rom_addr", 32'(rom_addr), 32'h123456);
        check("ch0_di", 32'(di), 32'hA0);
        check("ch0_rom_oe_n", 32'(rom_oe_n), 32'd0);
        ch_rom_addr[0 +: ROM_AW] = 24'h654321;
        #1;
        check("ch0_rom_addr_comb", 32'(rom_addr), 32'h654321);

        // Switch to channel 3 with idle channel 0: one DRAIN, four GUARD
        map_active = 4'b0100;
        tick();
        check("sw3_drain_switching", 32'(switching), 32'd1);
        check("sw3_drain_di", 32'(di), 32'hA0);
        tick();
        check("sw3_guard_di", 32'(di), 32'hFF);
        check("sw3_guard_rom_ce_n", 32'(rom_ce_n), 32'd1);
        check("sw3_guard_bsram_addr", 32'(bsram_addr), 32'd0);
        tick(); tick(); tick();
        check("sw3_guard_last", 32'(switching), 32'd1);
        tick();
        check("sw3_sel", 32'(sel_idx), 32'd3);
        check("sw3_switching", 32'(switching), 32'd0);
        check("sw3_turbo", 32'(turbo_allow), 32'd0);
        check("sw3_di", 32'(di), 32'hA3);
        check("sw3_bsram_addr", 32'(bsram_addr), 32'h03005);
        check("sw3_bsram_d", 32'(bsram_d), 32'h53);

        // Drain timeout: channel 3 holds its ROM strobe; DRAIN lasts exactly 64 cycles
        ch_rom_ce_n[3] = 1'b0;
        map_active = 4'b0000;
        tick();
        for (int i = 1; i < 64; i++) tick();
        check("to_still_drain_di", 32'(di), 32'hA3);
        check("to_still_drain_ce", 32'(rom_ce_n), 32'd0);
        tick();
        check("to_guard_di", 32'(di), 32'hFF);
        check("to_guard_ce", 32'(rom_ce_n), 32'd1);
        ch_rom_ce_n[3] = 1'b1;
        tick(); tick(); tick();
        check("to_guard_last", 32'(switching), 32'd1);
        tick();
        check("to_sel", 32'(sel_idx), 32'd0);
`ifdef CART_MAP_STATS_EN
        check("to_seen", 32'(drain_timeout_seen), 32'd1);
`endif

        // Multi-hot request: sticky error, falls back to channel 0
        map_active = 4'b0011;
        #1;
        check("mh_err_before", 32'(onehot_err), 32'd0);
        tick();
        check("mh_err_set", 32'(onehot_err), 32'd1);
        check("mh_no_switch", 32'(switching), 32'd0);
        check("mh_sel", 32'(sel_idx), 32'd0);
        map_active = 4'b0001;
        tick(); tick();
        check("mh_err_sticky", 32'(onehot_err), 32'd1);
        tick(); tick(); tick(); tick();
        check("sw1_sel", 32'(sel_idx), 32'd1);
        check("sw1_turbo", 32'(turbo_allow), 32'd0);
        check("sw1_err_sticky", 32'(onehot_err), 32'd1);

        // Request toggles to channel 2 and back within DRAIN: single re-select of channel 1
`ifdef CART_MAP_STATS_EN
        sc_before = switch_count;
`endif
        ch_rom_ce_n[1] = 1'b0;
        map_active = 4'b0010;
        tick();
        check("tg_drain", 32'(switching), 32'd1);
        map_active = 4'b0001;
        tick(); tick();
        check("tg_drain_pass_di", 32'(di), 32'hA1);
        ch_rom_ce_n[1] = 1'b1;
        tick();
        check("tg_guard_di", 32'(di), 32'hFF);
        tick(); tick(); tick();
        tick();
        check("tg_sel", 32'(sel_idx), 32'd1);
        check("tg_switching", 32'(switching), 32'd0);
        tick();
        check("tg_stays_run", 32'(switching), 32'd0);
`ifdef CART_MAP_STATS_EN
        check("tg_switch_count", 32'(switch_count), 32'(sc_before) + 32'd1);
`endif

        // Reset during GUARD toward channel 4
        map_active = 4'b1000;
        tick(); tick(); tick();
        check("rg_in_guard", 32'(di), 32'hFF);
        rst = 1'b1;
        tick();
        check("rg_sel", 32'(sel_idx), 32'd0);
        check("rg_switching", 32'(switching), 32'd1);
        check("rg_err_cleared", 32'(onehot_err), 32'd0);
        rst = 1'b0;
        tick(); tick(); tick();
        check("rg_guard_restart", 32'(switching), 32'd1);
        tick();
        check("rg_run_ch0", 32'(sel_idx), 32'd0);
        check("rg_run_switching", 32'(switching), 32'd0);
        tick(); tick();
        tick(); tick(); tick();
        check("sw4_guard_irq", 32'(irq_n), 32'd1);
        tick();
        check("sw4_sel", 32'(sel_idx), 32'd4);
        check("sw4_turbo", 32'(turbo_allow), 32'd1);
        check("sw4_irq", 32'(irq_n), 32'd0);
        check("sw4_rom_addr", 32'(rom_addr), 32'h400ABC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
